// File: rtl/music_pkg.sv
// Shared types, widths and the semitone divider table for the note sequencer.
package music_pkg;

    localparam int NOTE_W = 6;
    localparam int DIV_W  = 9;
    localparam int OCT_W  = 8;
    localparam int QUOT_W = 3;
    localparam int REM_W  = 4;
    localparam int DUR_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    localparam logic [DIV_W-1:0] NOTE_DIV [12] = '{
        9'd511, 9'd482, 9'd455, 9'd430, 9'd405, 9'd382,
        9'd361, 9'd341, 9'd322, 9'd303, 9'd286, 9'd270
    };

    // Table lookup by constant indices; out-of-range semitones fall back to entry 0.
    function automatic logic [DIV_W-1:0] note_div(input logic [REM_W-1:0] rem);
        logic [DIV_W-1:0] div;
        div = NOTE_DIV[0];
        for (int i = 0; i < 12; i++) begin
            if (rem == REM_W'(i)) div = NOTE_DIV[i];
        end
        return div;
    endfunction

endpackage

// File: rtl/divide_by12.sv
// Combinational split of a 6-bit note number into octave (note/12) and semitone (note%12).
module divide_by12 (
    input  logic [5:0] numer,
    output logic [2:0] quotient,
    output logic [3:0] remain
);

    logic [5:0] base;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        quotient = '0;
        base     = '0;
        for (int i = 1; i < 6; i++) begin
            if (numer >= 6'(12 * i)) begin
                quotient = 3'(i);
                base     = 6'(12 * i);
            end
        end
        remain = 4'(numer - base);
    end

endmodule

// File: rtl/tone_gen.sv
// Two-stage divider chain (semitone then octave) that toggles the speaker square wave.
module tone_gen
    import music_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load,
    input  logic [QUOT_W-1:0] quot,
    input  logic [REM_W-1:0]  rem,
    output logic              speaker
);

    logic [DIV_W-1:0] cnt_note;
    logic [DIV_W-1:0] div_rld;
    logic [OCT_W-1:0] cnt_oct;
    logic [OCT_W-1:0] oct_rld;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_note <= '0;
            div_rld  <= '0;
            cnt_oct  <= '0;
            oct_rld  <= '0;
            speaker  <= 1'b0;
        end else if (load) begin
            div_rld  <= note_div(rem);
            cnt_note <= note_div(rem);
            oct_rld  <= 8'hFF >> quot;
            cnt_oct  <= 8'hFF >> quot;
            speaker  <= 1'b0;
        end else if (enable) begin
            if (cnt_note == '0) begin
                cnt_note <= div_rld;
                if (cnt_oct == '0) begin
                    cnt_oct <= oct_rld;
                    speaker <= ~speaker;
                end else begin
                    cnt_oct <= cnt_oct - 1'b1;
                end
            end else begin
                cnt_note <= cnt_note - 1'b1;
            end
        end else begin
            // Any cycle without tone (rest, PLAY exit, stop, other states) is silent.
            speaker <= 1'b0;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a note ROM, playing each note for NOTE_LEN cycles followed by GAP_LEN silent cycles.
module note_sequencer
    import music_pkg::*;
#(
    parameter int NOTE_LEN = 4000000,
    parameter int GAP_LEN  = 400000,
    parameter int SONG_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [NOTE_W-1:0] note_addr,
    input  logic [NOTE_W-1:0] note_data,
    output logic              speaker,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_n;
    logic [DUR_W-1:0]  dur_cnt;
    logic [NOTE_W-1:0] note_q;
    logic [QUOT_W-1:0] quot;
    logic [REM_W-1:0]  rem;
    logic              play_last;
    logic              gap_last;
    logic              last_addr;
    logic              tone_en;
    logic              tone_load;

    assign play_last = (dur_cnt == DUR_W'(NOTE_LEN - 1));
    assign gap_last  = (dur_cnt == DUR_W'(GAP_LEN - 1));
    assign last_addr = (note_addr == NOTE_W'(SONG_LEN - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_n = FETCH;
                FETCH:   state_n = LOAD;
                LOAD:    state_n = PLAY;
                PLAY:    if (play_last) state_n = GAP;
                GAP:     if (gap_last) state_n = last_addr ? IDLE : FETCH;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dur_cnt   <= '0;
            note_addr <= '0;
            note_q    <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            done  <= !stop && (state == GAP) && gap_last && last_addr;

            // The duration counter restarts on every state change, so it never wraps inside a state.
            if ((state_n == state) && ((state == PLAY) || (state == GAP)))
                dur_cnt <= dur_cnt + 1'b1;
            else
                dur_cnt <= '0;

            if (state_n == IDLE)
                note_addr <= '0;
            else if ((state == GAP) && gap_last)
                note_addr <= note_addr + 1'b1;

            if (stop)
                note_q <= '0;
            else if (state == LOAD)
                note_q <= note_data;
        end
    end

    // ROM data is valid during LOAD; the tone counters load from it on the LOAD->PLAY edge.
    divide_by12 u_div (
        .numer    (note_data),
        .quotient (quot),
        .remain   (rem)
    );

    assign tone_load = (state == LOAD);
    assign tone_en   = (state == PLAY) && !stop && !play_last && (note_q != '0);

    tone_gen u_tone (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (tone_en),
        .load    (tone_load),
        .quot    (quot),
        .rem     (rem),
        .speaker (speaker)
    );

endmodule
